// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: operand-entry / result bus of the calculator ALU sequencer.
//   next        - raw pushbutton, active-low, asynchronous to clk
//   Din         - nibble to enter
//   MS          - operation select
//   level       - chain mode (1: result becomes A of the next calculation)
//   result      - last computed result (W = 4*NIB bits)
//   entry       - value under entry (A, B or result depending on state)
//   nib_cnt     - nibbles entered into the current operand
//   state_code  - current state encoding for the display
//   done        - high while the result is held
//   carry/zero/ovf - flags of the last operation
// The slave modport is the sequencer; the master modport is whatever drives the buttons.
interface alu_sequencer_if #(
  parameter int NIB = 4
);
  localparam int W = 4 * NIB;

  logic         next;
  logic [3:0]   Din;
  logic [2:0]   MS;
  logic         level;
  logic [W-1:0] result;
  logic [W-1:0] entry;
  logic [3:0]   nib_cnt;
  logic [3:0]   state_code;
  logic         done;
  logic         carry;
  logic         zero;
  logic         ovf;

  modport slave (
    input  next, Din, MS, level,
    output result, entry, nib_cnt, state_code, done, carry, zero, ovf
  );

  modport master (
    output next, Din, MS, level,
    input  result, entry, nib_cnt, state_code, done, carry, zero, ovf
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: collects two W-bit operands nibble by nibble (one button press per
// nibble, most significant nibble first), runs the selected ALU operation (single
// cycle, or W-cycle shift-add for multiply) and holds result and flags.
// Ports:
//   clk   - system clock, all state changes on the rising edge
//   clear - synchronous active-high reset, priority over everything
//   bus   - alu_sequencer_if.slave: next/Din/MS/level in, result/entry/nib_cnt/
//           state_code/done/carry/zero/ovf out
module alu_sequencer #(
  parameter int NIB = 4,
  parameter int SHW = $clog2(4 * NIB)
) (
  input logic            clk,
  input logic            clear,
  alu_sequencer_if.slave bus
);
  localparam int W  = 4 * NIB;
  localparam int CW = $clog2(W);

  typedef enum logic [3:0] {
    S_A    = 4'd1,
    S_B    = 4'd2,
    S_EXEC = 4'd3,
    S_MUL  = 4'd4,
    S_DONE = 4'd5
  } state_t;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
  } alu_out_t;

  // Single-cycle operations; multiply is sequenced separately in S_MUL.
  function automatic alu_out_t alu_eval(input logic [2:0] op,
                                        input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    alu_out_t          o;
    logic [W:0]        wide;
    logic [SHW-1:0]    sh;
    logic signed [W-1:0] sa, sb, sr;
    o    = '0;
    wide = '0;
    sh   = b[SHW-1:0];
    sa   = signed'(a);
    sb   = signed'(b);
    case (op)
      3'b000: begin
        wide  = {1'b0, a} + {1'b0, b};
        o.res = wide[W-1:0];
        o.c   = wide[W];
        sr    = signed'(o.res);
        o.v   = ((sa < 0) == (sb < 0)) && ((sr < 0) != (sa < 0));
      end
      3'b001: begin
        // The extra top bit of the W+1 bit difference is the borrow.
        wide  = {1'b0, a} - {1'b0, b};
        o.res = wide[W-1:0];
        o.c   = wide[W];
        sr    = signed'(o.res);
        o.v   = ((sa < 0) != (sb < 0)) && ((sr < 0) != (sa < 0));
      end
      3'b010: o.res = a & b;
      3'b011: o.res = a | b;
      3'b100: o.res = a ^ b;
      3'b101: begin
        // A guard bit above the operand catches the last bit shifted out.
        wide  = {1'b0, a} << sh;
        o.res = wide[W-1:0];
        o.c   = wide[W];
      end
      3'b110: begin
        wide  = {a, 1'b0} >> sh;
        o.res = wide[W:1];
        o.c   = wide[0];
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  state_t         state_q;
  logic [W-1:0]   a_q, b_q, result_q;
  logic [2*W-1:0] acc_q;
  logic [CW-1:0]  mcnt_q;
  logic [2:0]     op_q;
  logic [3:0]     nib_q;
  logic           done_q, carry_q, zero_q, ovf_q;
  logic           s1_q, s2_q, s3_q;
  logic           press;

  alu_out_t       alu_d;
  logic [2*W-1:0] addend_d, acc_d;
  logic [W-1:0]   entry_d;

  // s3 is the oldest sample: high-then-low is one falling edge of the button.
  assign press = s3_q & ~s2_q;

  assign alu_d = alu_eval(op_q, a_q, b_q);

  // One shift-add step: bit mcnt of B selects A shifted to that weight.
  always_comb begin
    addend_d = '0;
    if (b_q[mcnt_q]) addend_d = {{W{1'b0}}, a_q} << mcnt_q;
    acc_d = acc_q + addend_d;
  end

  always_comb begin
    entry_d = result_q;
    case (state_q)
      S_A:     entry_d = a_q;
      S_B:     entry_d = b_q;
      default: entry_d = result_q;
    endcase
  end

  assign bus.entry      = entry_d;
  assign bus.state_code = state_q;
  assign bus.result     = result_q;
  assign bus.nib_cnt    = nib_q;
  assign bus.done       = done_q;
  assign bus.carry      = carry_q;
  assign bus.zero       = zero_q;
  assign bus.ovf        = ovf_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q  <= S_A;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      acc_q    <= '0;
      mcnt_q   <= '0;
      op_q     <= '0;
      nib_q    <= '0;
      done_q   <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      // Loading zeros means a button held through reset is seen as "already low".
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
    end else begin
      s1_q <= bus.next;
      s2_q <= s1_q;
      s3_q <= s2_q;
      case (state_q)
        S_A: begin
          if (press) begin
            a_q <= {a_q[W-5:0], bus.Din};
            if (nib_q == 4'(NIB - 1)) begin
              nib_q   <= '0;
              state_q <= S_B;
            end else begin
              nib_q <= nib_q + 4'd1;
            end
          end
        end
        S_B: begin
          if (press) begin
            b_q <= {b_q[W-5:0], bus.Din};
            if (nib_q == 4'(NIB - 1)) begin
              nib_q   <= '0;
              op_q    <= bus.MS;
              state_q <= S_EXEC;
            end else begin
              nib_q <= nib_q + 4'd1;
            end
          end
        end
        S_EXEC: begin
          if (op_q == 3'b111) begin
            acc_q   <= '0;
            mcnt_q  <= '0;
            state_q <= S_MUL;
          end else begin
            result_q <= alu_d.res;
            carry_q  <= alu_d.c;
            ovf_q    <= alu_d.v;
            zero_q   <= (alu_d.res == '0);
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_MUL: begin
          acc_q <= acc_d;
          if (mcnt_q == CW'(W - 1)) begin
            result_q <= acc_d[W-1:0];
            carry_q  <= |acc_d[2*W-1:W];
            ovf_q    <= 1'b0;
            zero_q   <= (acc_d[W-1:0] == '0);
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            mcnt_q <= mcnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (press) begin
            done_q <= 1'b0;
            nib_q  <= '0;
            b_q    <= '0;
            if (bus.level) begin
              a_q     <= result_q;
              state_q <= S_B;
            end else begin
              a_q     <= '0;
              state_q <= S_A;
            end
          end
        end
        default: begin
          state_q <= S_A;
          nib_q   <= '0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule
